// File: rtl/ocm_dma_pkg.sv
// Shared types and helpers for the on-chip-memory DMA frame path.
// Capture states, memory geometry and pixel-lane byte-enable mapping.
package ocm_dma_pkg;

    localparam int OCM_WORDS  = 65536;
    localparam int OCM_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOP,
        RUN,
        FLUSH,
        DONE
    } ocm_state_e;

    function automatic logic [3:0] lanes_to_byteenable(
        input int filled_slots,
        input int pixel_w
    );
        int nbytes;
        nbytes = (filled_slots * pixel_w) / 8;
        if (nbytes >= 4) return 4'hF;
        return 4'((1 << nbytes) - 1);
    endfunction

endpackage

// File: rtl/ocm_pixel_packer.sv
// Packs PIXEL_W pixels little-endian into 32-bit words.
// A completed word is presented for exactly one cycle after its last beat.
module ocm_pixel_packer
    import ocm_dma_pkg::*;
#(
    parameter int PIXEL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               beat_i,
    input  logic [PIXEL_W-1:0] pixel_i,
    output logic               word_valid_o,
    output logic [31:0]        word_o,
    output logic               part_valid_o,
    output logic [31:0]        part_o,
    output logic [3:0]         part_be_o
);

    localparam int PPW = 32 / PIXEL_W;
    localparam int CW  = $clog2(PPW + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   word_q, word_d;
    logic          wvld_q, wvld_d;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        word_d = word_q;
        wvld_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (beat_i) begin
            for (int k = 0; k < PPW; k++) begin
                if (cnt_q == CW'(k)) acc_d[k*PIXEL_W +: PIXEL_W] = pixel_i;
            end
            if (cnt_q == CW'(PPW - 1)) begin
                word_d = acc_d;
                wvld_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            word_q <= '0;
            wvld_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            wvld_q <= wvld_d;
        end
    end

    assign word_valid_o = wvld_q;
    assign word_o       = word_q;
    assign part_valid_o = (cnt_q != '0);
    assign part_o       = acc_q;
    assign part_be_o    = lanes_to_byteenable(int'(cnt_q), PIXEL_W);

endmodule

// File: rtl/ocm_frame_writer.sv
// Streams one Avalon-ST pixel frame into the OCM second write port.
// Words land at base + n; writes past the word limit are dropped and flagged.
module ocm_frame_writer
    import ocm_dma_pkg::*;
#(
    parameter int PIXEL_W = 16,
    parameter int ADDR_W  = OCM_ADDR_W,
    parameter int CNT_W   = 17
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   word_limit,
    input  logic [PIXEL_W-1:0] snk_data,
    input  logic               snk_valid,
    input  logic               snk_sop,
    input  logic               snk_eop,
    output logic               snk_ready,
    output logic [ADDR_W-1:0]  m_address,
    output logic [31:0]        m_writedata,
    output logic [3:0]         m_byteenable,
    output logic               m_chipselect,
    output logic               m_write,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [CNT_W-1:0]   words_written,
    output logic               irq
);

    ocm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [CNT_W-1:0]  ww_q, ww_d;
    logic              ovf_q, ovf_d;
    logic              irq_q;

    logic        xfer, pack_beat, clear_pack;
    logic        wr_due, limit_hit, do_wr;
    logic        word_valid, part_valid;
    logic [31:0] word, part;
    logic [3:0]  part_be;

    ocm_pixel_packer #(.PIXEL_W(PIXEL_W)) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (clear_pack),
        .beat_i       (pack_beat),
        .pixel_i      (snk_data),
        .word_valid_o (word_valid),
        .word_o       (word),
        .part_valid_o (part_valid),
        .part_o       (part),
        .part_be_o    (part_be)
    );

    assign snk_ready = (state_q == WAIT_SOP) || (state_q == RUN);
    assign xfer      = snk_valid && snk_ready;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        limit_d    = limit_q;
        ww_d       = ww_q;
        ovf_d      = ovf_q;
        clear_pack = 1'b0;
        pack_beat  = 1'b0;
        wr_due     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d     = base_addr;
                    limit_d    = word_limit;
                    ww_d       = '0;
                    ovf_d      = 1'b0;
                    clear_pack = 1'b1;
                    state_d    = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (xfer && snk_sop) begin
                    pack_beat = 1'b1;
                    state_d   = snk_eop ? FLUSH : RUN;
                end
            end
            RUN: begin
                pack_beat = xfer;
                wr_due    = word_valid;
                if (xfer && snk_eop) state_d = FLUSH;
            end
            FLUSH: begin
                // A word completed by eop is pending here instead of a residual.
                wr_due  = word_valid || part_valid;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        limit_hit = (ww_q == limit_q);
        do_wr     = wr_due && !limit_hit;
        if (do_wr) ww_d = ww_q + CNT_W'(1);
        if (wr_due && limit_hit) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            limit_q <= '0;
            ww_q    <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            limit_q <= limit_d;
            ww_q    <= ww_d;
            ovf_q   <= ovf_d;
            irq_q   <= (state_q == FLUSH);
        end
    end

    assign m_write       = do_wr;
    assign m_chipselect  = do_wr;
    assign m_address     = do_wr ? base_q + ADDR_W'(ww_q) : '0;
    assign m_writedata   = do_wr ? (word_valid ? word : part) : '0;
    assign m_byteenable  = do_wr ? (word_valid ? 4'hF : part_be) : '0;
    assign busy          = snk_ready;
    assign done          = (state_q == DONE);
    assign overflow      = ovf_q;
    assign words_written = ww_q;
    assign irq           = irq_q;

endmodule
